// File: rtl/column_rr_sched.sv
// Round-robin merge of per-column FIFO streams into one registered valid/ready output.
// Define COLUMN_RR_SCHED_STATS_EN to add per-column grant counters (clr_stats, gnt_cnt).
module column_rr_sched #(
  parameter int COLS  = 4,
  parameter int DW    = 2,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic [COLS-1:0]           ival,
  input  logic [COLS-1:0][DW-1:0]   idata,
  output logic [COLS-1:0]           irdy,
  input  logic [COLS-1:0]           col_en,
  output logic                      oval,
  output logic [DW-1:0]             odata,
  output logic [$clog2(COLS)-1:0]   ocol,
  input  logic                      ordy,
  output logic                      busy
`ifdef COLUMN_RR_SCHED_STATS_EN
  ,
  input  logic                      clr_stats,
  output logic [COLS-1:0][15:0]     gnt_cnt
`endif
);

  localparam int CW = $clog2(COLS);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DW-1:0]   mem_q  [COLS][DEPTH];
  logic [PW-1:0]   wptr_q [COLS];
  logic [PW-1:0]   wptr_d [COLS];
  logic [PW-1:0]   rptr_q [COLS];
  logic [PW-1:0]   rptr_d [COLS];
  logic [COLS-1:0] empty;
  logic [COLS-1:0] full;
  logic [COLS-1:0] push;
  logic [COLS-1:0] pop;

  logic            found;
  logic [CW-1:0]   win;
  logic [CW-1:0]   sel;
  logic            load;

  logic            oval_q, oval_d;
  logic [DW-1:0]   odata_q, odata_d;
  logic [CW-1:0]   ocol_q, ocol_d;
  logic [CW-1:0]   rr_q, rr_d;

  // Extra pointer MSB tells a full FIFO apart from an empty one.
  always_comb begin
    empty = '0;
    full  = '0;
    for (int c = 0; c < COLS; c++) begin
      empty[c] = (wptr_q[c] == rptr_q[c]);
      full[c]  = (wptr_q[c][AW] != rptr_q[c][AW]) &&
                 (wptr_q[c][AW-1:0] == rptr_q[c][AW-1:0]);
    end
  end

  assign push = ival & ~full;

  // Scan columns starting at the round-robin pointer; first eligible one wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sel   = '0;
    for (int i = 0; i < COLS; i++) begin
      if (int'(rr_q) + i >= COLS) sel = CW'(int'(rr_q) + i - COLS);
      else                        sel = CW'(int'(rr_q) + i);
      if (!found && !empty[sel] && col_en[sel]) begin
        found = 1'b1;
        win   = sel;
      end
    end
  end

  always_comb begin
    load    = !oval_q || ordy;
    oval_d  = oval_q;
    odata_d = odata_q;
    ocol_d  = ocol_q;
    rr_d    = rr_q;
    pop     = '0;
    if (load) begin
      oval_d = found;
      if (found) begin
        odata_d = mem_q[win][rptr_q[win][AW-1:0]];
        ocol_d  = win;
        rr_d    = (win == CW'(COLS - 1)) ? '0 : win + CW'(1);
        for (int c = 0; c < COLS; c++) pop[c] = (win == CW'(c));
      end
    end
  end

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      wptr_d[c] = push[c] ? wptr_q[c] + PW'(1) : wptr_q[c];
      rptr_d[c] = pop[c]  ? rptr_q[c] + PW'(1) : rptr_q[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      for (int c = 0; c < COLS; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
      end
      oval_q  <= 1'b0;
      odata_q <= '0;
      ocol_q  <= '0;
      rr_q    <= '0;
    end else begin
      for (int c = 0; c < COLS; c++) begin
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
      end
      oval_q  <= oval_d;
      odata_q <= odata_d;
      ocol_q  <= ocol_d;
      rr_q    <= rr_d;
    end
  end

  // Storage needs no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      for (int c = 0; c < COLS; c++) begin
        if (push[c]) mem_q[c][wptr_q[c][AW-1:0]] <= idata[c];
      end
    end
  end

  assign irdy  = ~full;
  assign oval  = oval_q;
  assign odata = odata_q;
  assign ocol  = ocol_q;
  assign busy  = (|(~empty)) | oval_q;

`ifdef COLUMN_RR_SCHED_STATS_EN
  logic [COLS-1:0][15:0] gnt_cnt_q;

  // Clear wins over a same-cycle grant; counts stick at all-ones.
  always_ff @(posedge clk) begin
    if (rstb || clr_stats) begin
      gnt_cnt_q <= '0;
    end else begin
      for (int c = 0; c < COLS; c++) begin
        if (pop[c] && gnt_cnt_q[c] != 16'hFFFF) gnt_cnt_q[c] <= gnt_cnt_q[c] + 16'd1;
      end
    end
  end

  assign gnt_cnt = gnt_cnt_q;
`endif

endmodule

// File: tb/tb_column_rr_sched.sv
// Self-checking bench for column_rr_sched: queue-based reference model plus directed checks.
module tb_column_rr_sched;

  localparam int COLS  = 4;
  localparam int DW    = 2;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(COLS);

  logic                    clk = 1'b0;
  logic                    rstb;
  logic [COLS-1:0]         ival;
  logic [COLS-1:0][DW-1:0] idata;
  logic [COLS-1:0]         irdy;
  logic [COLS-1:0]         col_en;
  logic                    oval;
  logic [DW-1:0]           odata;
  logic [CW-1:0]           ocol;
  logic                    ordy;
  logic                    busy;
`ifdef COLUMN_RR_SCHED_STATS_EN
  logic                    clr_stats;
  logic [COLS-1:0][15:0]   gnt_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state: plain per-column queues held as arrays with counts.
  int            mcnt [COLS];
  logic [DW-1:0] mbuf [COLS][DEPTH];
  int            mgnt [COLS];
  int            mrr;
  bit            mov;
  logic [DW-1:0] modata;
  int            mocol;
  bit            modelValid = 1'b0;
  int            w;
  int            mc;
  bit            pushOk [COLS];
  logic [COLS-1:0] expIrdy;
  bit            expBusy;

  column_rr_sched #(.COLS(COLS), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rstb   (rstb),
    .ival   (ival),
    .idata  (idata),
    .irdy   (irdy),
    .col_en (col_en),
    .oval   (oval),
    .odata  (odata),
    .ocol   (ocol),
    .ordy   (ordy),
    .busy   (busy)
`ifdef COLUMN_RR_SCHED_STATS_EN
    ,
    .clr_stats (clr_stats),
    .gnt_cnt   (gnt_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [COLS-1:0] v, input logic [COLS-1:0][DW-1:0] d);
    ival  = v;
    idata = d;
    @(negedge clk);
  endtask

  task automatic doReset();
    rstb = 1'b1;
    applyStimulus('0, '0);
    rstb = 1'b0;
    applyStimulus('0, '0);
  endtask

  // Model update on each rising edge from the inputs the DUT also samples.
  always @(posedge clk) begin
    if (rstb) begin
      for (int c = 0; c < COLS; c++) begin
        mcnt[c] = 0;
        mgnt[c] = 0;
      end
      mrr        = 0;
      mov        = 1'b0;
      modata     = '0;
      mocol      = 0;
      modelValid = 1'b1;
    end else begin
      for (int c = 0; c < COLS; c++) pushOk[c] = ival[c] && (mcnt[c] < DEPTH);
      if (!mov || ordy) begin
        w = -1;
        for (int i = 0; i < COLS; i++) begin
          mc = (mrr + i) % COLS;
          if (w < 0 && mcnt[mc] > 0 && col_en[mc]) w = mc;
        end
        if (w >= 0) begin
          modata = mbuf[w][0];
          for (int k = 0; k < DEPTH - 1; k++) mbuf[w][k] = mbuf[w][k+1];
          mcnt[w]--;
          mocol = w;
          mov   = 1'b1;
          mrr   = (w + 1) % COLS;
          if (mgnt[w] < 65535) mgnt[w]++;
        end else begin
          mov = 1'b0;
        end
      end
      for (int c = 0; c < COLS; c++) begin
        if (pushOk[c]) begin
          mbuf[c][mcnt[c]] = idata[c];
          mcnt[c]++;
        end
      end
`ifdef COLUMN_RR_SCHED_STATS_EN
      if (clr_stats) for (int c = 0; c < COLS; c++) mgnt[c] = 0;
`endif
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (modelValid) begin
      expBusy = mov;
      for (int c = 0; c < COLS; c++) begin
        expIrdy[c] = (mcnt[c] < DEPTH);
        if (mcnt[c] > 0) expBusy = 1'b1;
      end
      checkOutput("model_oval", 32'(oval), 32'(mov));
      if (mov) begin
        checkOutput("model_odata", 32'(odata), 32'(modata));
        checkOutput("model_ocol", 32'(ocol), 32'(mocol));
      end
      checkOutput("model_irdy", 32'(irdy), 32'(expIrdy));
      checkOutput("model_busy", 32'(busy), 32'(expBusy));
`ifdef COLUMN_RR_SCHED_STATS_EN
      for (int c = 0; c < COLS; c++) checkOutput("model_gnt_cnt", 32'(gnt_cnt[c]), 32'(mgnt[c]));
`endif
    end
  end

  initial begin
    rstb   = 1'b1;
    ival   = '1;
    idata  = '1;
    col_en = '1;
    ordy   = 1'b1;
`ifdef COLUMN_RR_SCHED_STATS_EN
    clr_stats = 1'b0;
`endif

    // Reset held three cycles with pushes offered.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput("rst_oval", 32'(oval), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_odata", 32'(odata), 32'd0);
      checkOutput("rst_ocol", 32'(ocol), 32'd0);
      if (i < 2) applyStimulus('1, '1);
    end
    rstb = 1'b0;
    applyStimulus('0, '0);
    checkOutput("rel_irdy", 32'(irdy), 32'hF);
    checkOutput("rel_oval", 32'(oval), 32'd0);
    checkOutput("rel_busy", 32'(busy), 32'd0);

    // Single beat on column 2.
    applyStimulus(4'b0100, {2'd0, 2'd3, 2'd0, 2'd0});
    checkOutput("single_n1_oval", 32'(oval), 32'd0);
    applyStimulus('0, '0);
    checkOutput("single_oval", 32'(oval), 32'd1);
    checkOutput("single_odata", 32'(odata), 32'd3);
    checkOutput("single_ocol", 32'(ocol), 32'd2);
    applyStimulus('0, '0);
    checkOutput("single_n3_oval", 32'(oval), 32'd0);

    // Fairness: two beats per column, then enable everything.
    doReset();
    col_en = '0;
    applyStimulus('1, {2'd3, 2'd2, 2'd1, 2'd0});
    applyStimulus('1, {2'd3, 2'd2, 2'd1, 2'd0});
    checkOutput("rr_full_irdy", 32'(irdy), 32'd0);
    col_en = '1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus('0, '0);
      checkOutput("rr_oval", 32'(oval), 32'd1);
      checkOutput("rr_ocol", 32'(ocol), 32'(i % COLS));
      checkOutput("rr_odata", 32'(odata), 32'(i % COLS));
    end
    applyStimulus('0, '0);
    checkOutput("rr_end_busy", 32'(busy), 32'd0);

    // Backpressure fills column 1.
    doReset();
    ordy = 1'b0;
    applyStimulus(4'b0010, {2'd0, 2'd0, 2'd1, 2'd0});
    applyStimulus(4'b0010, {2'd0, 2'd0, 2'd2, 2'd0});
    applyStimulus(4'b0010, {2'd0, 2'd0, 2'd3, 2'd0});
    checkOutput("bp_irdy1", 32'(irdy[1]), 32'd0);
    checkOutput("bp_odata", 32'(odata), 32'd1);
    checkOutput("bp_ocol", 32'(ocol), 32'd1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(4'b0010, '0);
      checkOutput("bp_hold_oval", 32'(oval), 32'd1);
      checkOutput("bp_hold_odata", 32'(odata), 32'd1);
      checkOutput("bp_hold_irdy1", 32'(irdy[1]), 32'd0);
    end
    applyStimulus('0, '0);
    ordy = 1'b1;
    applyStimulus('0, '0);
    checkOutput("bp_pop_odata", 32'(odata), 32'd2);
    checkOutput("bp_pop_irdy1", 32'(irdy[1]), 32'd1);
    applyStimulus('0, '0);
    checkOutput("bp_last_odata", 32'(odata), 32'd3);
    applyStimulus('0, '0);
    checkOutput("bp_end_oval", 32'(oval), 32'd0);
    checkOutput("bp_end_busy", 32'(busy), 32'd0);

    // Column 2 masked until re-enabled.
    doReset();
    col_en = 4'b1011;
    applyStimulus(4'b1101, {2'd3, 2'd2, 2'd0, 2'd1});
    applyStimulus('0, '0);
    checkOutput("mask_ocol0", 32'(ocol), 32'd0);
    checkOutput("mask_odata0", 32'(odata), 32'd1);
    applyStimulus('0, '0);
    checkOutput("mask_ocol3", 32'(ocol), 32'd3);
    checkOutput("mask_odata3", 32'(odata), 32'd3);
    applyStimulus('0, '0);
    checkOutput("mask_idle_oval", 32'(oval), 32'd0);
    checkOutput("mask_idle_busy", 32'(busy), 32'd1);
    applyStimulus('0, '0);
    checkOutput("mask_idle2_oval", 32'(oval), 32'd0);
    col_en = '1;
    applyStimulus('0, '0);
    checkOutput("mask_en_oval", 32'(oval), 32'd1);
    checkOutput("mask_en_ocol", 32'(ocol), 32'd2);
    checkOutput("mask_en_odata", 32'(odata), 32'd2);
    applyStimulus('0, '0);
    checkOutput("mask_end_busy", 32'(busy), 32'd0);

    // Stream from column 0, stall with two queued, then reset mid-flight.
    doReset();
    for (int k = 0; k < 6; k++) applyStimulus(4'b0001, {6'd0, 2'(k % 4)});
    ordy = 1'b0;
    applyStimulus(4'b0001, {6'd0, 2'd2});
    checkOutput("midrst_irdy0", 32'(irdy[0]), 32'd0);
    checkOutput("midrst_oval", 32'(oval), 32'd1);
`ifdef COLUMN_RR_SCHED_STATS_EN
    checkOutput("midrst_gnt0", 32'(gnt_cnt[0]), 32'd5);
`endif
    rstb = 1'b1;
    applyStimulus('0, '0);
    checkOutput("midrst_rst_oval", 32'(oval), 32'd0);
    checkOutput("midrst_rst_busy", 32'(busy), 32'd0);
`ifdef COLUMN_RR_SCHED_STATS_EN
    checkOutput("midrst_gnt_zero", 32'(gnt_cnt), 32'd0);
`endif
    rstb = 1'b0;
    ordy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus('0, '0);
      checkOutput("midrst_after_oval", 32'(oval), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/column_rr_sched.md
Name: column_rr_sched

Overview:
- Round-robin scheduler merging per-column valid/data streams from the COLS column instances in a generate loop into one serial output stream.
- Each column gets a small FIFO with ready backpressure.
- A registered output stage carries a valid/ready handshake and tags each beat with its source column index.
- Sits between the column array and the shared downstream consumer.

Parameters:
- COLS, 4, number of requesting columns (2..16).
- DW, 2, data width per column beat.
- DEPTH, 2, per-column FIFO depth; power of two, 2..8.

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rstb  input  1  synchronous, active-high reset.
- ival  input  [COLS-1:0]  per-column push valid.
- idata  input  [COLS-1:0][DW-1:0]  per-column push data.
- irdy  output  [COLS-1:0]  per-column ready; high when that column's FIFO is not full.
- col_en  input  [COLS-1:0]  grant-eligibility mask; 0 = column never granted.
- oval  output  1  output beat valid.
- odata  output  [DW-1:0]  output beat data.
- ocol  output  $clog2(COLS)  source column of the current beat.
- ordy  input  1  downstream ready.
- busy  output  1  high when any FIFO is non-empty or oval=1.

Behaviour:
- Reset is synchronous and active-high on rstb, sampled on clk rising edge. When rstb=1:
  - all FIFOs are emptied;
  - round-robin pointer rr_ptr=0;
  - oval=0, odata=0, ocol=0, busy=0;
  - irdy=all-ones from the first cycle after reset.
- Reset mid-operation discards all queued and presented beats without emitting them.
- Push: column c writes its FIFO on a clk edge where ival[c]&irdy[c].
  - irdy[c] = !full[c], purely from FIFO state.
  - There is no bypass; a pop in the same cycle does not raise irdy on a full FIFO.
  - ival while irdy=0 is ignored (upstream must hold).
- Output stage advances when load = !oval | ordy. On advance:
  - Winner = first column c, scanning rr_ptr, rr_ptr+1, ... mod COLS, with FIFO non-empty and col_en[c]=1.
  - If a winner exists: pop its head into odata, set ocol=c, oval=1, rr_ptr=(c+1) mod COLS.
  - If none exists: oval=0 and rr_ptr is unchanged.
- Hold rule: oval=1 & ordy=0 holds odata/ocol/oval stable; no pop, no pointer change.
- Latency: beat pushed on edge N is in the FIFO for cycle N+1; earliest oval=1 is cycle N+2. With ordy held high, throughput is 1 beat/cycle.
- Fairness: with all columns continuously non-empty and enabled, grants cycle 0,1,...,COLS-1,0,...
- Per-column ordering is FIFO.
- Simultaneous push and pop of the same FIFO in one cycle keeps occupancy unchanged. When the FIFO is empty and the push/pop coincide, no pop is possible, since the pop only sees prior-cycle contents.
- col_en deasserted for a non-empty column: its entries stay queued. It keeps accepting pushes until full, then holds irdy=0.
- col_en changes take effect at the next load decision; a beat already presented is unaffected.
- FIFO pointers are $clog2(DEPTH)+1 bits; full/empty come from MSB compare; wrap is natural binary rollover.
- busy = |(~empty) | oval.

Optional Feature:
- Macro: COLUMN_RR_SCHED_STATS_EN.
- With the macro defined:
  - adds input clr_stats (1) and output gnt_cnt [COLS-1:0][15:0];
  - gnt_cnt[c] increments on every output-stage load that selects column c, saturating at 16'hFFFF;
  - clr_stats=1 zeroes all counters the next edge and has priority over an increment in that cycle;
  - rstb also zeroes all counters.
- Without the macro: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset/idle: assert rstb 3 cycles with ival=4'hF, then release. Required during reset: oval=0, busy=0, no FIFO writes. Required after release: irdy=4'hF, oval=0.
- Single beat: push col 2 data 2'b11 at edge N, ordy=1. Required: oval=1, odata=3, ocol=2 in cycle N+2, oval=0 in N+3.
- Round-robin fairness: preload each column with 2 beats (col c data = c), ordy=1, col_en=4'hF. Required: ocol sequence 0,1,2,3,0,1,2,3 on consecutive cycles, then busy=0.
- Backpressure/full:
  - Hold ordy=0 and push col 1 three times.
  - Required: one beat is presented and held stable, the FIFO fills to DEPTH=2, and irdy[1]=0.
  - Raise ordy; required: irdy[1] returns to 1 one cycle after the first pop; no beat is lost or duplicated.
- Mask: col_en=4'b1011 with cols 0, 2, 3 non-empty. Required: col 2 is never granted and stays queued. Then set col_en=4'hF; required: col 2 is granted at its round-robin turn.
- Mid-operation reset plus stats (with COLUMN_RR_SCHED_STATS_EN):
  - Stream 5 beats from col 0, then assert rstb with 2 beats still queued.
  - Required: gnt_cnt[0]=5 before reset; after reset all counters are 0, oval=0, and the queued beats never appear.
